// File: rtl/psk_frame_serializer.sv
// PSK frame serializer: buffers payload bytes in a small FIFO and streams
// preamble, sync word and payload as 2-bit symbols to the PSK modulator.
module psk_frame_serializer #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned START_THRESH = 8,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter logic [15:0] SYNC_WORD    = 16'h1ACF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_enable,
  input  logic       mode_bpsk,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       underrun
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT   = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] THRESH_CNT = START_THRESH[AW:0];
  localparam logic [7:0]  PRE_LAST   = 8'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StSync,
    StPayload
  } state_t;

  // ---------------------------------------------------------------------------
  // Payload FIFO: entries are {tlast, data}
  // ---------------------------------------------------------------------------
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_last_cnt;  // number of buffered bytes carrying tlast

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [8:0] w_head;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign s_tready = rst_n & ~w_full;
  assign w_push   = s_tvalid & s_tready & clk_enable;
  assign w_head   = r_mem[r_rptr];

  // FIFO storage write; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_tlast, s_tdata};
    end
  end

  // FIFO pointers, occupancy and count of buffered packet ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count    <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      r_last_cnt <= r_last_cnt + {{AW{1'b0}}, w_push & s_tlast}
                               - {{AW{1'b0}}, w_pop & w_head[8]};
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol extraction helpers (MSB first)
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] sync_sym(input logic [4:0] idx, input logic bpsk);
    logic [15:0] sh;
    if (bpsk) begin
      sh = SYNC_WORD << idx;
      return {sh[15], sh[15]};
    end
    sh = SYNC_WORD << {idx[3:0], 1'b0};
    return sh[15:14];
  endfunction

  function automatic logic [1:0] byte_sym(input logic [7:0] b, input logic [2:0] idx,
                                          input logic bpsk);
    logic [7:0] sh;
    if (bpsk) begin
      sh = b << idx;
      return {sh[7], sh[7]};
    end
    sh = b << {idx[1:0], 1'b0};
    return sh[7:6];
  endfunction

  // ---------------------------------------------------------------------------
  // Framing FSM. The output registers hold the symbol currently offered; the
  // counters index that symbol, so a handshake loads the next one directly.
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [7:0] r_pre_cnt;
  logic [4:0] r_sync_cnt;
  logic [2:0] r_sym_cnt;
  logic [7:0] r_byte;
  logic       r_byte_last;
  logic [1:0] r_tdata;
  logic       r_tvalid;
  logic       r_tlast;
  logic       r_tuser;
  logic       r_underrun;

  state_t     w_state_nxt;
  logic [7:0] w_pre_cnt_nxt;
  logic [4:0] w_sync_cnt_nxt;
  logic [2:0] w_sym_cnt_nxt;
  logic [7:0] w_byte_nxt;
  logic       w_byte_last_nxt;
  logic [1:0] w_tdata_nxt;
  logic       w_tvalid_nxt;
  logic       w_tlast_nxt;
  logic       w_tuser_nxt;
  logic       w_underrun_nxt;
  logic       w_xfer;
  logic       w_load;
  logic       w_start;
  logic [2:0] w_sym_last;
  logic [4:0] w_sync_last;

  assign w_xfer      = r_tvalid & m_tready;
  assign w_start     = (r_count >= THRESH_CNT) || (r_last_cnt != '0);
  assign w_sym_last  = r_tuser ? 3'd7 : 3'd3;
  assign w_sync_last = r_tuser ? 5'd15 : 5'd7;

  // FSM state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pre_cnt   <= '0;
      r_sync_cnt  <= '0;
      r_sym_cnt   <= '0;
      r_byte      <= '0;
      r_byte_last <= 1'b0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_sync_cnt  <= w_sync_cnt_nxt;
      r_sym_cnt   <= w_sym_cnt_nxt;
      r_byte      <= w_byte_nxt;
      r_byte_last <= w_byte_last_nxt;
      r_tdata     <= w_tdata_nxt;
      r_tvalid    <= w_tvalid_nxt;
      r_tlast     <= w_tlast_nxt;
      r_tuser     <= w_tuser_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

  // Next-state and next-symbol selection; nothing moves while clk_enable is low
  always_comb begin
    w_state_nxt     = r_state;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_sync_cnt_nxt  = r_sync_cnt;
    w_sym_cnt_nxt   = r_sym_cnt;
    w_byte_nxt      = r_byte;
    w_byte_last_nxt = r_byte_last;
    w_tdata_nxt     = r_tdata;
    w_tvalid_nxt    = r_tvalid;
    w_tlast_nxt     = r_tlast;
    w_tuser_nxt     = r_tuser;
    w_underrun_nxt  = r_underrun;
    w_pop           = 1'b0;
    w_load          = 1'b0;

    if (clk_enable) begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            w_state_nxt    = StPreamble;
            w_tuser_nxt    = mode_bpsk;
            w_underrun_nxt = 1'b0;
            w_pre_cnt_nxt  = '0;
            w_tdata_nxt    = 2'b00;
            w_tvalid_nxt   = 1'b1;
            w_tlast_nxt    = 1'b0;
          end
        end

        StPreamble: begin
          if (w_xfer) begin
            if (r_pre_cnt == PRE_LAST) begin
              w_state_nxt    = StSync;
              w_sync_cnt_nxt = '0;
              w_tdata_nxt    = sync_sym(5'd0, r_tuser);
            end else begin
              w_pre_cnt_nxt = r_pre_cnt + 8'd1;
              w_tdata_nxt   = w_pre_cnt_nxt[0] ? 2'b11 : 2'b00;
            end
          end
        end

        StSync: begin
          if (w_xfer) begin
            if (r_sync_cnt == w_sync_last) begin
              w_state_nxt = StPayload;
              w_load      = 1'b1;
            end else begin
              w_sync_cnt_nxt = r_sync_cnt + 5'd1;
              w_tdata_nxt    = sync_sym(w_sync_cnt_nxt, r_tuser);
            end
          end
        end

        StPayload: begin
          if (!r_tvalid) begin
            // Stalled on an empty FIFO at a byte boundary: retry every cycle
            w_load = 1'b1;
          end else if (w_xfer) begin
            if (r_sym_cnt == w_sym_last) begin
              if (r_byte_last) begin
                w_state_nxt  = StIdle;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
                w_tdata_nxt  = 2'b00;
              end else begin
                w_load = 1'b1;
              end
            end else begin
              w_sym_cnt_nxt = r_sym_cnt + 3'd1;
              w_tdata_nxt   = byte_sym(r_byte, w_sym_cnt_nxt, r_tuser);
              w_tlast_nxt   = r_byte_last && (w_sym_cnt_nxt == w_sym_last);
            end
          end
        end

        default: begin
          w_state_nxt = StIdle;
        end
      endcase

      // Byte boundary: fetch the next payload byte or flag an underrun
      if (w_load) begin
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_byte_nxt      = w_head[7:0];
          w_byte_last_nxt = w_head[8];
          w_sym_cnt_nxt   = '0;
          w_tdata_nxt     = byte_sym(w_head[7:0], 3'd0, r_tuser);
          w_tvalid_nxt    = 1'b1;
          w_tlast_nxt     = 1'b0;
        end else begin
          w_tvalid_nxt   = 1'b0;
          w_tlast_nxt    = 1'b0;
          w_underrun_nxt = 1'b1;
        end
      end
    end
  end

  assign m_tdata  = {6'b000000, r_tdata};
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign m_tuser  = r_tuser;
  assign underrun = r_underrun;

endmodule
